// File: rtl/ram_fifo_pkg.sv
// Shared constants for the RAM-backed streaming FIFO, its RAM wrapper and bench.
package ram_fifo_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int LEVEL_W  = ADDR_W + 1;
    localparam int CAPACITY = DEPTH + 2;
endpackage

// File: rtl/ram_fifo_ostage.sv
// Two-entry head/skid output stage that absorbs the RAM's one-cycle read latency.
module ram_fifo_ostage
    import ram_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              cap,
    input  logic [DATA_W-1:0] cap_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        ost_cnt
);
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] head_n;
    logic [DATA_W-1:0] skid_n;
    logic [1:0]        cnt_mid;
    logic [1:0]        cnt_n;

    always_comb begin
        head_n  = head;
        skid_n  = skid_q;
        cnt_mid = ost_cnt;
        cnt_n   = ost_cnt;
        if (flush) begin
            cnt_n = 2'd0;
        end else begin
            if (pop && ost_cnt != 2'd0) begin
                cnt_mid = ost_cnt - 2'd1;
                if (ost_cnt == 2'd2) head_n = skid_q;
            end
            cnt_n = cnt_mid;
            // Capture lands in head whenever head is empty after this cycle's pop.
            if (cap) begin
                if (cnt_mid == 2'd0) head_n = cap_data;
                else                 skid_n = cap_data;
                cnt_n = cnt_mid + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            skid_q  <= '0;
            ost_cnt <= 2'd0;
        end else begin
            head    <= head_n;
            skid_q  <= skid_n;
            ost_cnt <= cnt_n;
        end
    end
endmodule

// File: rtl/ram_fifo_ctrl.sv
// Streaming FIFO controller over an 8x16 dual-port RAM with registered read data.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [LEVEL_W-1:0] level,
    output logic               ram_rst,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_waddr,
    output logic [DATA_W-1:0]  ram_wdata,
    output logic               ram_re,
    output logic [ADDR_W-1:0]  ram_raddr,
    input  logic [DATA_W-1:0]  ram_rdata
);
    logic [ADDR_W-1:0]  wptr;
    logic [ADDR_W-1:0]  rptr;
    logic [LEVEL_W-1:0] ram_cnt;
    logic               rd_pend;
    logic               push;
    logic               pop;
    logic               cap;
    logic [1:0]         ost_cnt;
    logic [2:0]         ost_demand;

    assign ram_rst   = !rst_n;
    assign in_ready  = rst_n && !flush && (ram_cnt < LEVEL_W'(DEPTH));
    assign push      = in_valid && in_ready;
    assign out_valid = (ost_cnt != 2'd0);
    assign pop       = out_valid && out_ready && !flush;

    // Only read when the output stage is guaranteed a free slot for the returning word.
    assign ost_demand = 3'(ost_cnt) + 3'(rd_pend) - 3'(pop);
    assign ram_re     = rst_n && !flush && (ram_cnt != '0) && (ost_demand < 3'd2);

    assign ram_we    = push;
    assign ram_waddr = wptr;
    assign ram_wdata = in_data;
    assign ram_raddr = rptr;
    assign cap       = rd_pend && !flush;
    assign level     = ram_cnt + LEVEL_W'(rd_pend) + LEVEL_W'(ost_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            rd_pend <= 1'b0;
        end else if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            rd_pend <= 1'b0;
        end else begin
            if (push)   wptr <= wptr + 1'b1;
            if (ram_re) rptr <= rptr + 1'b1;
            ram_cnt <= ram_cnt + LEVEL_W'(push) - LEVEL_W'(ram_re);
            rd_pend <= ram_re;
        end
    end

    ram_fifo_ostage u_ostage (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .cap      (cap),
        .cap_data (ram_rdata),
        .pop      (pop),
        .head     (out_data),
        .ost_cnt  (ost_cnt)
    );
endmodule
